// File: rtl/pc_fetch_if.sv
// Fetch-control bundle between the PC/fetch stage and its upstream control logic.
// The slave side is the fetch unit; the master side drives redirects, stalls and halt requests.
interface pc_fetch_if;
    logic        stall;
    logic [1:0]  pc_src;
    logic [31:0] branch_target;
    logic [31:0] jalr_target;
    logic        halt_req;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        halted;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [31:0] fetch_count;

    modport master (
        output stall, pc_src, branch_target, jalr_target, halt_req,
        input  pc, pc_plus4, fetch_valid, halted, trap, trap_cause, fetch_count
    );

    modport slave (
        input  stall, pc_src, branch_target, jalr_target, halt_req,
        output pc, pc_plus4, fetch_valid, halted, trap, trap_cause, fetch_count
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch control: picks sequential/branch/JALR next PC, honours stalls,
// traps on misaligned or out-of-range targets and tracks boot/run/halt/trap state.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_DEPTH = 1024
) (
    input logic       clk,
    input logic       rst,
    pc_fetch_if.slave bus
);

    typedef enum logic [1:0] {StBoot, StRun, StHalt, StTrap} state_e;

    // 33 bits so a full 4 GiB memory depth does not overflow the limit
    localparam logic [32:0] PcLimit = 33'(IMEM_DEPTH) * 33'd4;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] count_q, count_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        case (bus.pc_src)
            2'b01:   next_pc = bus.branch_target;
            2'b10:   next_pc = bus.jalr_target & ~32'd1;
            default: next_pc = pc_plus4;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        cause_d = cause_q;
        case (state_q)
            StBoot: state_d = StRun;
            StRun: begin
                // Halt beats both stall and any redirect presented in the same cycle
                if (bus.halt_req) begin
                    state_d = StHalt;
                end else if (!bus.stall) begin
                    if (next_pc[1:0] != 2'b00) begin
                        state_d = StTrap;
                        cause_d = 2'b01;
                    end else if ({1'b0, next_pc} >= PcLimit) begin
                        state_d = StTrap;
                        cause_d = 2'b10;
                    end else begin
                        pc_d    = next_pc;
                        count_d = count_q + 32'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StBoot;
            pc_q    <= RESET_PC;
            count_q <= 32'd0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            cause_q <= cause_d;
        end
    end

    // Status flags are masked while reset is asserted so nothing looks live mid-reset
    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_plus4;
    assign bus.fetch_valid = (state_q == StRun) && !bus.stall && !rst;
    assign bus.halted      = (state_q == StHalt) && !rst;
    assign bus.trap        = (state_q == StTrap) && !rst;
    assign bus.trap_cause  = rst ? 2'b00 : cause_q;
    assign bus.fetch_count = count_q;

endmodule
